// File: rtl/uart_apb_pkg.sv
// Shared register map, bit positions and serial FSM state encoding for the APB UART.
package uart_apb_pkg;
    localparam int DIV_W = 16;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_IE     = 2'd3;

    localparam int STS_TX_FULL    = 0;
    localparam int STS_TX_EMPTY   = 1;
    localparam int STS_RX_EMPTY   = 2;
    localparam int STS_RX_FULL    = 3;
    localparam int STS_TX_BUSY    = 4;
    localparam int STS_TX_OVF     = 5;
    localparam int STS_RX_OVF     = 6;
    localparam int STS_FRAME_ERR  = 7;
    localparam int STS_PARITY_ERR = 8;

    localparam int CTRL_TX_EN   = 16;
    localparam int CTRL_RX_EN   = 17;
    localparam int CTRL_PAR_ODD = 18;

    localparam int IE_RX_AVAIL = 0;
    localparam int IE_TX_EMPTY = 1;
    localparam int IE_ERR      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count. A pop on empty is ignored; a push on
// full is accepted only when a pop frees the slot in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/uart_apb_fifo.sv
// APB3 UART with TX/RX FIFOs, programmable divisor, sticky errors and level irq.
// Optional parity frame bit is built when UART_PARITY_EN is defined.
module uart_apb_fifo
    import uart_apb_pkg::*;
#(
    parameter int               DATA_BITS = 8,
    parameter int               TX_DEPTH  = 16,
    parameter int               RX_DEPTH  = 16,
    parameter logic [DIV_W-1:0] DIV_RESET = 16'd867
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic        in_pwrite,
    input  logic [31:0] in_paddr,
    input  logic [31:0] in_pwdata,
    output logic [31:0] in_prdata,
    output logic        in_pready,
    output logic        in_pslverr,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
    localparam uart_state_t POST_DATA = ST_PARITY;
`else
    localparam uart_state_t POST_DATA = ST_STOP;
`endif

    logic acc, bad_addr, wr_acc, rd_acc, w1c;
    logic [1:0] reg_sel;
    logic [DIV_W-1:0] div;
    logic tx_en, rx_en, par_odd;
    logic [2:0] ie;
    logic tx_ovf, rx_ovf, frame_err, parity_err;
    logic [STS_PARITY_ERR:0] status;
    logic [STS_PARITY_ERR:STS_TX_OVF] clr;
    logic [DIV_W:0] div_inc;

    logic tx_push, tx_pop, tx_full, tx_empty;
    logic rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_BITS-1:0] tx_head, rx_head;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [$clog2(RX_DEPTH):0] rx_count;

    uart_state_t tx_state, tx_state_n, rx_state, rx_state_n;
    logic [DIV_W-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [DIV_W-1:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [IDX_W-1:0] tx_idx, tx_idx_n, rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n, rx_shift, rx_shift_n;
    logic tx_par, tx_par_n, tx_line_n;
    logic rx_s1, rx_s2, rx_prev, rx_fall;
    logic tx_ovf_set, rx_ovf_set, frame_set, par_set;
    logic unused_bits;

    assign acc        = in_psel & in_penable;
    assign bad_addr   = |in_paddr[11:4];
    assign in_pready  = acc;
    assign in_pslverr = acc & bad_addr;
    assign wr_acc     = acc & ~bad_addr & in_pwrite;
    assign rd_acc     = acc & ~bad_addr & ~in_pwrite;
    assign reg_sel    = in_paddr[3:2];
    assign w1c        = wr_acc & (reg_sel == REG_STATUS);
    assign clr        = w1c ? in_pwdata[STS_PARITY_ERR:STS_TX_OVF] : '0;
    assign tx_push    = wr_acc & (reg_sel == REG_DATA);
    assign rx_pop     = rd_acc & (reg_sel == REG_DATA) & ~rx_empty;
    assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
    assign rx_ovf_set = rx_push & rx_full & ~rx_pop;
    assign div_inc    = {1'b0, div} + 1'b1;
    assign rx_fall    = rx_prev & ~rx_s2;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock(clock), .reset(reset), .push(tx_push), .wdata(in_pwdata[DATA_BITS-1:0]),
        .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock(clock), .reset(reset), .push(rx_push), .wdata(rx_shift),
        .pop(rx_pop), .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_comb begin
        status                 = '0;
        status[STS_TX_FULL]    = tx_full;
        status[STS_TX_EMPTY]   = tx_empty;
        status[STS_RX_EMPTY]   = rx_empty;
        status[STS_RX_FULL]    = rx_full;
        status[STS_TX_BUSY]    = (tx_state != ST_IDLE);
        status[STS_TX_OVF]     = tx_ovf;
        status[STS_RX_OVF]     = rx_ovf;
        status[STS_FRAME_ERR]  = frame_err;
        status[STS_PARITY_ERR] = parity_err;
    end

    always_comb begin
        in_prdata = '0;
        if (rd_acc) begin
            case (reg_sel)
                REG_DATA:   if (!rx_empty) in_prdata[DATA_BITS-1:0] = rx_head;
                REG_STATUS: in_prdata[STS_PARITY_ERR:0] = status;
                REG_CTRL:   in_prdata[CTRL_PAR_ODD:0] = {par_odd, rx_en, tx_en, div};
                default:    in_prdata[2:0] = ie;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            div <= DIV_RESET;
            tx_en <= 1'b1;
            rx_en <= 1'b1;
            ie <= '0;
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
            frame_err <= 1'b0;
            irq <= 1'b0;
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            if (wr_acc && reg_sel == REG_CTRL) begin
                div <= in_pwdata[DIV_W-1:0];
                tx_en <= in_pwdata[CTRL_TX_EN];
                rx_en <= in_pwdata[CTRL_RX_EN];
            end
            if (wr_acc && reg_sel == REG_IE) ie <= in_pwdata[2:0];
            // A hardware set in the same cycle as a W1C keeps the flag set.
            tx_ovf    <= tx_ovf_set | (tx_ovf & ~clr[STS_TX_OVF]);
            rx_ovf    <= rx_ovf_set | (rx_ovf & ~clr[STS_RX_OVF]);
            frame_err <= frame_set | (frame_err & ~clr[STS_FRAME_ERR]);
            irq <= (ie[IE_RX_AVAIL] & ~rx_empty) | (ie[IE_TX_EMPTY] & tx_empty)
                 | (ie[IE_ERR] & |status[STS_PARITY_ERR:STS_TX_OVF]);
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            par_odd <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (wr_acc && reg_sel == REG_CTRL) par_odd <= in_pwdata[CTRL_PAR_ODD];
            parity_err <= par_set | (parity_err & ~clr[STS_PARITY_ERR]);
        end
    end
`else
    assign par_odd    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_div_n   = tx_div;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_pop     = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                if (tx_en && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = ST_START;
                    tx_cnt_n   = div;
                    tx_div_n   = div;
                    tx_shift_n = tx_head;
                    tx_par_n   = ^tx_head ^ par_odd;
                end
            end
            default: begin
                if (tx_cnt != '0) begin
                    tx_cnt_n = tx_cnt - 1'b1;
                end else begin
                    tx_cnt_n = tx_div;
                    case (tx_state)
                        ST_START: begin
                            tx_state_n = ST_DATA;
                            tx_idx_n   = '0;
                        end
                        ST_DATA: begin
                            tx_shift_n = tx_shift >> 1;
                            if (tx_idx == IDX_LAST) tx_state_n = POST_DATA;
                            else                    tx_idx_n   = tx_idx + 1'b1;
                        end
                        ST_PARITY: tx_state_n = ST_STOP;
                        default:   tx_state_n = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Serial output is registered from the next-state view so it never glitches.
    always_comb begin
        case (tx_state_n)
            ST_START:  tx_line_n = 1'b0;
            ST_DATA:   tx_line_n = tx_shift_n[0];
            ST_PARITY: tx_line_n = tx_par_n;
            default:   tx_line_n = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_div_n   = rx_div;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        par_set    = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (rx_en && rx_fall) begin
                    rx_state_n = ST_START;
                    rx_div_n   = div;
                    rx_cnt_n   = div_inc[DIV_W:1];
                end
            end
            default: begin
                if (rx_cnt != '0) begin
                    rx_cnt_n = rx_cnt - 1'b1;
                end else begin
                    rx_cnt_n = rx_div;
                    case (rx_state)
                        ST_START: begin
                            if (rx_s2) begin
                                rx_state_n = ST_IDLE;
                            end else begin
                                rx_state_n = ST_DATA;
                                rx_idx_n   = '0;
                            end
                        end
                        ST_DATA: begin
                            rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
                            if (rx_idx == IDX_LAST) rx_state_n = POST_DATA;
                            else                    rx_idx_n   = rx_idx + 1'b1;
                        end
                        ST_PARITY: begin
                            par_set    = (rx_s2 != (^rx_shift ^ par_odd));
                            rx_state_n = ST_STOP;
                        end
                        default: begin
                            rx_state_n = ST_IDLE;
                            rx_push    = rx_s2;
                            frame_set  = ~rx_s2;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state <= ST_IDLE;
            rx_state <= ST_IDLE;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            rx_state <= rx_state_n;
            uart_tx  <= tx_line_n;
        end
    end

    always_ff @(posedge clock) begin
        tx_cnt   <= tx_cnt_n;
        tx_div   <= tx_div_n;
        tx_idx   <= tx_idx_n;
        tx_shift <= tx_shift_n;
        tx_par   <= tx_par_n;
        rx_cnt   <= rx_cnt_n;
        rx_div   <= rx_div_n;
        rx_idx   <= rx_idx_n;
        rx_shift <= rx_shift_n;
    end

    assign unused_bits = ^{in_paddr[31:12], in_paddr[1:0], in_pwdata[31:CTRL_PAR_ODD],
                           tx_count, rx_count, clr[STS_PARITY_ERR], par_set};
endmodule

// File: tb/tb_uart_apb_fifo.sv
// Directed bench for uart_apb_fifo: register access, TX framing, loopback RX,
// error flags, slave error and glitch rejection in the default 8N1 build.
module tb_uart_apb_fifo;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        uart_rx, uart_tx, irq;
    logic        loop = 1'b0;
    logic        rx_drive = 1'b1;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] rd;
    logic        err, rdy;
    logic [39:0] cap, exp_wave;
    logic [9:0]  frame;

    assign uart_rx = loop ? uart_tx : rx_drive;

    always #5 clock = ~clock;

    uart_apb_fifo dut (
        .clock(clock), .reset(reset),
        .in_psel(psel), .in_penable(penable), .in_pwrite(pwrite),
        .in_paddr(paddr), .in_pwdata(pwdata), .in_prdata(prdata),
        .in_pready(pready), .in_pslverr(pslverr),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge clock);
        penable = 1'b1;
        @(negedge clock);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic slv_err, output logic ready);
        @(negedge clock);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge clock);
        penable = 1'b1;
        #1;
        data = prdata; slv_err = pslverr; ready = pready;
        @(negedge clock);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_bit, input int bit_clks);
        @(negedge clock);
        rx_drive = 1'b0;
        repeat (bit_clks) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_drive = d[i];
            repeat (bit_clks) @(negedge clock);
        end
        rx_drive = stop_bit;
        repeat (bit_clks) @(negedge clock);
        rx_drive = 1'b1;
        repeat (bit_clks + 4) @(negedge clock);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and register defaults
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("reset_uart_tx", uart_tx, 1);
        check("reset_irq", irq, 0);
        check("idle_prdata", prdata, 0);
        apb_read(32'h4, rd, err, rdy);
        check("reset_status", rd, 32'h06);
        apb_read(32'h8, rd, err, rdy);
        check("reset_ctrl", rd, 32'h0003_0363);
        apb_read(32'hC, rd, err, rdy);
        check("reset_ie", rd, 32'h0);

        // TX framing of 0x55 at div=3
        apb_write(32'h8, 32'h0003_0003);
        apb_write(32'h0, 32'h55);
        for (int i = 0; i < 50 && uart_tx !== 1'b0; i++) @(negedge clock);
        for (int i = 0; i < 40; i++) begin
            cap[i] = uart_tx;
            @(negedge clock);
        end
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 40; i++) exp_wave[i] = frame[i / 4];
        check("tx_wave_55", cap, exp_wave);
        check("tx_idle_after_stop", uart_tx, 1);
        apb_read(32'h4, rd, err, rdy);
        check("status_after_tx", rd, 32'h06);

        // TX overflow with transmitter disabled, then W1C
        apb_write(32'h8, 32'h0002_0003);
        for (int i = 0; i < 17; i++) apb_write(32'h0, 32'(i));
        apb_read(32'h4, rd, err, rdy);
        check("status_tx_full_ovf", rd, 32'h25);
        apb_write(32'h4, 32'h20);
        apb_read(32'h4, rd, err, rdy);
        check("status_ovf_cleared", rd, 32'h05);

        // Reset flushes the FIFO and restores CTRL
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        check("reset2_uart_tx", uart_tx, 1);
        apb_read(32'h4, rd, err, rdy);
        check("reset2_status", rd, 32'h06);
        apb_read(32'h8, rd, err, rdy);
        check("reset2_ctrl", rd, 32'h0003_0363);

        // Loopback 0xA3 with rx_avail interrupt
        apb_write(32'h8, 32'h0003_0003);
        loop = 1'b1;
        apb_write(32'hC, 32'h1);
        apb_write(32'h0, 32'hA3);
        apb_read(32'h4, rd, err, rdy);
        check("status_tx_busy", rd, 32'h16);
        check("irq_before_rx", irq, 0);
        for (int i = 0; i < 200 && irq !== 1'b1; i++) @(negedge clock);
        check("irq_rx_avail", irq, 1);
        apb_read(32'h0, rd, err, rdy);
        check("loop_data", rd, 32'hA3);
        @(negedge clock);
        check("irq_after_pop", irq, 0);
        apb_read(32'h4, rd, err, rdy);
        check("status_after_pop", rd, 32'h06);
        apb_read(32'h0, rd, err, rdy);
        check("read_empty_rx", rd, 32'h0);
        loop = 1'b0;

        // Framing error: 0x3C with stop bit 0, then a good 0x3C
        send_rx(8'h3C, 1'b0, 4);
        apb_read(32'h4, rd, err, rdy);
        check("status_frame_err", rd, 32'h86);
        apb_write(32'h4, 32'h80);
        apb_read(32'h4, rd, err, rdy);
        check("frame_err_cleared", rd, 32'h06);
        send_rx(8'h3C, 1'b1, 4);
        apb_read(32'h0, rd, err, rdy);
        check("rx_data_3c", rd, 32'h3C);

        // Slave error accesses have no effect
        apb_read(32'h10, rd, err, rdy);
        check("slverr_flag", err, 1);
        check("slverr_ready", rdy, 1);
        check("slverr_rdata", rd, 32'h0);
        apb_write(32'h18, 32'h0);
        apb_write(32'h10, 32'h77);
        apb_read(32'h8, rd, err, rdy);
        check("ctrl_unchanged", rd, 32'h0003_0003);
        check("good_addr_no_err", err, 0);
        apb_read(32'h4, rd, err, rdy);
        check("status_unchanged", rd, 32'h06);

        // One-clock glitch at div=7 is rejected; a real frame still lands
        apb_write(32'h8, 32'h0003_0007);
        @(negedge clock);
        rx_drive = 1'b0;
        @(negedge clock);
        rx_drive = 1'b1;
        repeat (40) @(negedge clock);
        apb_read(32'h4, rd, err, rdy);
        check("glitch_rejected", rd, 32'h06);
        send_rx(8'hC5, 1'b1, 8);
        apb_read(32'h0, rd, err, rdy);
        check("rx_data_c5_div7", rd, 32'hC5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
